// File: rtl/program_counter.sv
// Program-counter register for the single-cycle MIPS datapath: loads the next-PC
// value on each enabled clock edge and exposes PC + INC plus valid/alignment status.
module program_counter #(
    parameter int unsigned     N_bit       = 32,
    parameter longint unsigned RESET_VALUE = 64'd0,
    parameter int unsigned     INC         = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [N_bit-1:0] PC_dash,
    output logic [N_bit-1:0] PC,
    output logic [N_bit-1:0] PC_plus,
    output logic             PC_valid,
    output logic             PC_misaligned
);

    localparam logic [N_bit-1:0] RST_PC     = N_bit'(RESET_VALUE);
    localparam logic [N_bit-1:0] INC_W      = N_bit'(INC);
    localparam int unsigned      ALIGN_BITS = $clog2(INC);

    // Reject increments that are not a power of two or do not fit the PC width.
    if ((N_bit == 32'd0) || (INC == 32'd0) || ((INC & (INC - 32'd1)) != 32'd0) ||
        ((N_bit < 32'd32) && (INC >= (32'd1 << N_bit)))) begin : g_bad_inc
        $error("program_counter: INC must be a power of two with 1 <= INC < 2**N_bit");
    end

    logic [N_bit-1:0] pc_d, pc_q;
    logic             pc_valid_d, pc_valid_q;

    // Next-state selection: load on enable, otherwise hold.
    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = pc_valid_q;
        if (en) begin
            pc_d       = PC_dash;
            pc_valid_d = 1'b1;
        end else begin
            pc_d       = pc_q;
            pc_valid_d = pc_valid_q;
        end
    end

    // State registers; the reset input is active-high despite its name.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            pc_q       <= RST_PC;
            pc_valid_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
        end
    end

    assign PC       = pc_q;
    assign PC_valid = pc_valid_q;
    assign PC_plus  = pc_q + INC_W;

    if (ALIGN_BITS == 0) begin : g_no_align
        assign PC_misaligned = 1'b0;
    end else begin : g_align
        assign PC_misaligned = |pc_q[ALIGN_BITS-1:0];
    end

    program_counter_chk #(.N_bit(N_bit)) u_chk (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .PC_dash (PC_dash)
    );

endmodule

// Run-time checks kept apart from the datapath; ignored by synthesis.
module program_counter_chk #(
    parameter int unsigned N_bit = 32
) (
    input logic             clk,
    input logic             reset_n,
    input logic             en,
    input logic [N_bit-1:0] PC_dash
);

    // An unknown next-PC being loaded would poison every later fetch.
    always @(posedge clk) begin
        if (!reset_n && en) begin
            assert (!$isunknown(PC_dash))
            else $error("program_counter: X on PC_dash while loading");
        end
    end

endmodule

// File: tb/tb_program_counter.sv
// Directed plus randomized bench for program_counter in two configurations
// (4-bit/INC=1 and 32-bit/INC=4/RESET_VALUE=0x00400000) against an arithmetic model.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  dash_a;
    logic [31:0] dash_b;
    logic [3:0]  pc_a, plus_a;
    logic [31:0] pc_b, plus_b;
    logic        valid_a, valid_b, mis_a, mis_b;

    int checks = 0;
    int errors = 0;

    longint unsigned m_pc_a, m_pc_b;
    bit              m_val_a, m_val_b;

    always #5 clk = ~clk;

    program_counter #(.N_bit(4), .RESET_VALUE(64'd0), .INC(1)) dut_a (
        .clk(clk), .reset_n(rst), .en(en), .PC_dash(dash_a),
        .PC(pc_a), .PC_plus(plus_a), .PC_valid(valid_a), .PC_misaligned(mis_a)
    );

    program_counter #(.N_bit(32), .RESET_VALUE(64'h0040_0000), .INC(4)) dut_b (
        .clk(clk), .reset_n(rst), .en(en), .PC_dash(dash_b),
        .PC(pc_b), .PC_plus(plus_b), .PC_valid(valid_b), .PC_misaligned(mis_b)
    );

    task automatic check(input string tag, input string what,
                         input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s.%s: observed 0x%0h expected 0x%0h", tag, what, obs, exp);
        end
    endtask

    // Expected outputs follow from the model PC by plain modular arithmetic.
    task automatic check_all(input string tag);
        check(tag, "a.pc",    64'(pc_a),    m_pc_a);
        check(tag, "a.plus",  64'(plus_a),  (m_pc_a + 64'd1) % 64'd16);
        check(tag, "a.valid", 64'(valid_a), 64'(m_val_a));
        check(tag, "a.mis",   64'(mis_a),   64'd0);
        check(tag, "b.pc",    64'(pc_b),    m_pc_b);
        check(tag, "b.plus",  64'(plus_b),  (m_pc_b + 64'd4) % 64'h1_0000_0000);
        check(tag, "b.valid", 64'(valid_b), 64'(m_val_b));
        check(tag, "b.mis",   64'(mis_b),   64'((m_pc_b % 64'd4) != 64'd0));
    endtask

    task automatic drive(input logic r, input logic e, input logic [3:0] da, input logic [31:0] db);
        @(negedge clk);
        rst    = r;
        en     = e;
        dash_a = da;
        dash_b = db;
    endtask

    // One rising edge: apply the load rules to the model, then compare.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst) begin
            m_pc_a  = 64'd0;
            m_pc_b  = 64'h0040_0000;
            m_val_a = 1'b0;
            m_val_b = 1'b0;
        end else if (en) begin
            m_pc_a  = 64'(dash_a);
            m_pc_b  = 64'(dash_b);
            m_val_a = 1'b1;
            m_val_b = 1'b1;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        dash_a = 4'd0;
        dash_b = 32'd0;

        // 1: reset, then first load and hold with the same PC_dash
        tick("reset");
        check("reset", "a.pc_const", 64'(pc_a), 64'h0);
        check("reset", "b.pc_const", 64'(pc_b), 64'h0040_0000);
        check("reset", "b.plus_const", 64'(plus_b), 64'h0040_0004);
        drive(1'b0, 1'b0, 4'd9, 32'h1234_5678);
        tick("stall_invalid");
        tick("stall_invalid2");
        drive(1'b0, 1'b1, 4'd1, 32'h0040_0006);
        tick("first_load");
        check("first_load", "b.mis_const", 64'(mis_b), 64'd1);
        tick("hold_same");

        // 2: reset asserted between edges has no effect until the edge
        drive(1'b1, 1'b1, 4'd1, 32'h0040_0006);
        #1;
        check_all("mid_reset_pre");
        tick("mid_reset");
        drive(1'b0, 1'b1, 4'd2, 32'h0040_0008);
        tick("post_reset_load");

        // 3: PC_dash change between edges is not visible until the edge
        drive(1'b0, 1'b1, 4'd4, 32'h0040_000C);
        #2;
        check_all("dash_change_pre");
        tick("dash_change");

        // 4: stall for three edges, then load all-ones to see wrap
        drive(1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF);
        tick("stall1");
        tick("stall2");
        tick("stall3");
        drive(1'b0, 1'b1, 4'hF, 32'hFFFF_FFFC);
        tick("wrap");
        check("wrap", "a.plus_const", 64'(plus_a), 64'h0);
        check("wrap", "b.plus_const", 64'(plus_b), 64'h0);

        // 6: reset wins over a simultaneous enable
        drive(1'b1, 1'b1, 4'h7, 32'hFFFF_FFFC);
        tick("reset_wins");

        // Randomized traffic with occasional reset and stalls
        for (int i = 0; i < 300; i++) begin
            logic [31:0] db;
            db = $urandom;
            if (($urandom % 4) != 0) db[1:0] = 2'b00;
            drive(($urandom % 16) == 0, ($urandom % 4) != 0, 4'($urandom), db);
            tick("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
Program-counter register for the single-cycle MIPS datapath. It holds the address of the current instruction and, on every clock edge, loads the next-PC value computed by the surrounding next-PC logic (PC_dash). It also exposes a sequential-successor address and status flags to the fetch and next-PC logic.

Parameters:
N_bit, 32, width of PC and all address ports.
RESET_VALUE, 0, value PC takes on reset; truncated to N_bit.
INC, 4, sequential increment used for PC_plus; must be a power of two, and 1 <= INC < 2^N_bit.

Ports:
clk  input  1  sole clock; all state updates on its rising edge.
reset_n  input  1  synchronous, active-high reset (name retained from the codebase; asserted = 1).
en  input  1  load enable; 1 = load PC_dash, 0 = hold/stall. Tie to 1 for plain single-cycle use.
PC_dash  input  N_bit  next-PC value to be loaded.
PC  output  N_bit  current program counter (registered).
PC_plus  output  N_bit  PC + INC modulo 2^N_bit (combinational from PC).
PC_valid  output  1  0 until the first load after reset, 1 thereafter (registered).
PC_misaligned  output  1  1 when the low log2(INC) bits of PC are nonzero; constant 0 when INC = 1.

Behaviour:
- Only clk edges change state; there is no asynchronous path. Asserting reset_n between edges has no effect until the next rising edge.
- Priority at each rising edge:
  1) reset_n = 1: PC <= RESET_VALUE, PC_valid <= 0. en and PC_dash are ignored.
  2) else if en = 1: PC <= PC_dash, PC_valid <= 1.
  3) else: PC and PC_valid hold their values.
- Latency: PC_dash appears on PC one rising edge after it is sampled. There is no combinational path from PC_dash to PC.
- Power-up: PC is undefined (X) until the first edge with reset_n = 1. This is an accepted condition, not a defect.
- Reset mid-operation: takes effect at the next edge regardless of the PC value. After reset_n deasserts, the next edge with en = 1 loads PC_dash normally.
- Arithmetic: PC_plus = (PC + INC) mod 2^N_bit. Wrap-around is silent (all-ones + 1 gives 0 when INC = 1). There is no overflow flag.
- PC_dash is loaded verbatim, with no masking or alignment. PC_misaligned only reports misalignment; it does not correct it.
- PC_plus and PC_misaligned are pure functions of PC and update with it.
- Stall (en = 0) while PC_valid = 0 keeps PC at RESET_VALUE and PC_valid at 0.
- No latches. Every register is assigned under every branch or holds explicitly.
- Implementation elements:
  - PC register and PC_valid flip-flop.
  - Combinational PC_plus adder and misalignment decode.
  - Parameter sanity checks (elaboration-time error if INC is not a power of two or is >= 2^N_bit).
  - Assertion-style checks for X on PC_dash while en = 1 outside reset.

Test Plan:
1. N_bit=4, INC=1. Hold reset_n=1 across one edge -> PC=0000, PC_valid=0, PC_plus=0001. Then reset_n=0, en=1, PC_dash=0001 -> after the next edge PC=0001, PC_valid=1, and PC stays 0001 on subsequent edges.
2. Reset mid-run: PC=0001, assert reset_n=1 mid-cycle -> PC unchanged until the next rising edge, then PC=0000 and PC_valid=0. Deassert with PC_dash=0010 -> PC=0010 after one edge.
3. Change PC_dash from 0010 to 0100 between edges -> PC stays 0010 until the next edge, then becomes 0100; no glitch between edges.
4. Stall: en=0 with PC=0100 and PC_dash=1111 for 3 edges -> PC stays 0100. Set en=1 -> PC=1111 after one edge, with PC_plus=0000 (wrap).
5. N_bit=32, INC=4, RESET_VALUE=0x00400000. Reset -> PC=0x00400000, PC_plus=0x00400004, PC_misaligned=0. Load PC_dash=0x00400006 -> PC_misaligned=1.
6. Simultaneous reset_n=1 and en=1 with PC_dash=0xFFFFFFFC -> PC=RESET_VALUE (reset wins).
